// File: rtl/mcpu_mem_avl_pkg.sv
// Shared widths, write-FSM state and read-command record for the Avalon-MM memory responder.
package mcpu_mem_avl_pkg;

    localparam int AVL_ADDR_W = 25;
    localparam int AVL_DATA_W = 128;
    localparam int AVL_BE_W   = 16;
    localparam int AVL_SIZE_W = 5;
    localparam int CD_W       = 4;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        WBURST = 1'b1
    } wr_state_e;

    typedef struct packed {
        logic [AVL_ADDR_W-1:0] base;
        logic [AVL_SIZE_W-1:0] size;
        logic [CD_W-1:0]       countdown;
    } rd_cmd_t;

    // A zero-length burst is carried out as a single beat.
    function automatic logic [AVL_SIZE_W-1:0] eff_size(input logic [AVL_SIZE_W-1:0] size);
        return (size == '0) ? AVL_SIZE_W'(1) : size;
    endfunction

endpackage

// File: rtl/mcpu_mem_avl_rdq.sv
// Read-command FIFO; every entry's latency countdown runs from its push, head-ready when the head reaches zero.
module mcpu_mem_avl_rdq
    import mcpu_mem_avl_pkg::*;
#(
    parameter int CMDQ_LOG2 = 2
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    push,
    input  rd_cmd_t push_cmd,
    input  logic    pop,
    output rd_cmd_t head_cmd,
    output logic    head_ready,
    output logic    full,
    output logic    empty
);

    localparam int DEPTH = 1 << CMDQ_LOG2;

    rd_cmd_t            entry_q [DEPTH];
    logic [CMDQ_LOG2:0] wr_ptr_q;
    logic [CMDQ_LOG2:0] rd_ptr_q;

    assign empty      = (wr_ptr_q == rd_ptr_q);
    assign full       = (wr_ptr_q[CMDQ_LOG2] != rd_ptr_q[CMDQ_LOG2]) &&
                        (wr_ptr_q[CMDQ_LOG2-1:0] == rd_ptr_q[CMDQ_LOG2-1:0]);
    assign head_cmd   = entry_q[rd_ptr_q[CMDQ_LOG2-1:0]];
    assign head_ready = !empty && (head_cmd.countdown == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (entry_q[i].countdown != '0) begin
                    entry_q[i].countdown <= entry_q[i].countdown - 1'b1;
                end
            end
            if (push) begin
                entry_q[wr_ptr_q[CMDQ_LOG2-1:0]] <= push_cmd;
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mcpu_mem_avl_responder.sv
// Avalon-MM burst responder standing in for the DDR controller behind the last-level cache.
//   state  | meaning
//   IDLE   | no write burst open; reads and new write bursts may be accepted
//   WBURST | write burst in progress, wr_rem_q beats still expected
module mcpu_mem_avl_responder
    import mcpu_mem_avl_pkg::*;
#(
    parameter int          MEM_LOG2     = 10,
    parameter int          READ_LATENCY = 4,
    parameter int          CMDQ_LOG2    = 2,
    parameter bit          STALL_EN     = 1'b0,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic                  clkrst_mem_clk,
    input  logic                  clkrst_mem_rst_n,
    input  logic [AVL_ADDR_W-1:0] ltc2mc_avl_addr_0,
    input  logic [AVL_BE_W-1:0]   ltc2mc_avl_be_0,
    input  logic                  ltc2mc_avl_burstbegin_0,
    input  logic                  ltc2mc_avl_read_req_0,
    input  logic                  ltc2mc_avl_write_req_0,
    input  logic [AVL_SIZE_W-1:0] ltc2mc_avl_size_0,
    input  logic [AVL_DATA_W-1:0] ltc2mc_avl_wdata_0,
    output logic                  ltc2mc_avl_ready_0,
    output logic [AVL_DATA_W-1:0] ltc2mc_avl_rdata_0,
    output logic                  ltc2mc_avl_rdata_valid_0,
    output logic                  avl_err
);

    localparam int          MEM_DEPTH = 1 << MEM_LOG2;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    logic                  rst_sync_q;
    logic [15:0]           lfsr_q;
    logic                  stall;
    wr_state_e             state_q;
    wr_state_e             state_d;
    logic [MEM_LOG2-1:0]   wr_ptr_q;
    logic [AVL_SIZE_W-1:0] wr_rem_q;
    logic [AVL_SIZE_W-1:0] req_size;
    logic                  accept;
    logic                  rd_acc;
    logic                  wr_start;
    logic                  wr_cont;
    logic                  err_set;
    logic                  wr_en;
    logic [MEM_LOG2-1:0]   wr_addr;
    logic                  rd_busy;
    logic                  cmdq_full;
    logic                  cmdq_empty;
    logic                  head_ready;
    logic                  pop;
    logic                  rd_en;
    logic [MEM_LOG2-1:0]   rd_addr;
    logic [MEM_LOG2-1:0]   rd_ptr_q;
    logic [AVL_SIZE_W-1:0] rd_rem_q;
    rd_cmd_t               push_cmd;
    rd_cmd_t               head_cmd;
    logic [AVL_DATA_W-1:0] mem_q [MEM_DEPTH];
    logic                  unused_bits;

    assign unused_bits = ^{head_cmd.base[AVL_ADDR_W-1:MEM_LOG2], head_cmd.countdown};

    always_ff @(posedge clkrst_mem_clk or negedge clkrst_mem_rst_n) begin
        if (!clkrst_mem_rst_n) begin
            rst_sync_q <= 1'b0;
        end else begin
            rst_sync_q <= 1'b1;
        end
    end

    always_ff @(posedge clkrst_mem_clk or negedge clkrst_mem_rst_n) begin
        if (!clkrst_mem_rst_n) begin
            lfsr_q <= LFSR_SEED;
        end else if (lfsr_q[0]) begin
            lfsr_q <= (lfsr_q >> 1) ^ LFSR_TAPS;
        end else begin
            lfsr_q <= lfsr_q >> 1;
        end
    end

    assign stall = STALL_EN && (lfsr_q[1:0] == 2'b00);

    // Holding off a new write burst until reads drain keeps read data ordered against writes.
    assign rd_busy  = !cmdq_empty || (rd_rem_q != '0) || ltc2mc_avl_rdata_valid_0;
    assign ltc2mc_avl_ready_0 = rst_sync_q && !stall && !cmdq_full &&
                                !(ltc2mc_avl_write_req_0 && (state_q == IDLE) && rd_busy);
    assign accept   = ltc2mc_avl_ready_0 && (ltc2mc_avl_read_req_0 || ltc2mc_avl_write_req_0);
    assign req_size = eff_size(ltc2mc_avl_size_0);

    always_ff @(posedge clkrst_mem_clk or negedge clkrst_mem_rst_n) begin
        if (!clkrst_mem_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (wr_start) begin
            state_d = (req_size != AVL_SIZE_W'(1)) ? WBURST : IDLE;
        end else if (wr_cont && (wr_rem_q == AVL_SIZE_W'(1))) begin
            state_d = IDLE;
        end
    end

    always_comb begin
        rd_acc   = 1'b0;
        wr_start = 1'b0;
        wr_cont  = 1'b0;
        err_set  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept && ltc2mc_avl_read_req_0) begin
                    rd_acc  = ltc2mc_avl_burstbegin_0;
                    err_set = ltc2mc_avl_write_req_0 ||
                              (ltc2mc_avl_burstbegin_0 && (ltc2mc_avl_size_0 == '0));
                end else if (accept) begin
                    wr_start = ltc2mc_avl_burstbegin_0;
                    err_set  = !ltc2mc_avl_burstbegin_0 || (ltc2mc_avl_size_0 == '0);
                end
            end
            WBURST: begin
                if (accept) begin
                    wr_start = ltc2mc_avl_write_req_0 && ltc2mc_avl_burstbegin_0;
                    wr_cont  = ltc2mc_avl_write_req_0 && !ltc2mc_avl_burstbegin_0;
                    err_set  = ltc2mc_avl_read_req_0 || ltc2mc_avl_burstbegin_0;
                end
            end
            default: ;
        endcase
    end

    assign wr_en   = wr_start || wr_cont;
    assign wr_addr = wr_start ? ltc2mc_avl_addr_0[MEM_LOG2-1:0] : wr_ptr_q;

    always_ff @(posedge clkrst_mem_clk or negedge clkrst_mem_rst_n) begin
        if (!clkrst_mem_rst_n) begin
            wr_ptr_q <= '0;
            wr_rem_q <= '0;
        end else if (wr_start) begin
            wr_ptr_q <= ltc2mc_avl_addr_0[MEM_LOG2-1:0] + 1'b1;
            wr_rem_q <= req_size - 1'b1;
        end else if (wr_cont) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
            wr_rem_q <= wr_rem_q - 1'b1;
        end
    end

    always_ff @(posedge clkrst_mem_clk) begin
        if (wr_en) begin
            for (int b = 0; b < AVL_BE_W; b++) begin
                if (ltc2mc_avl_be_0[b]) begin
                    mem_q[wr_addr][8*b +: 8] <= ltc2mc_avl_wdata_0[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        push_cmd.base      = ltc2mc_avl_addr_0;
        push_cmd.size      = req_size;
        push_cmd.countdown = CD_W'(READ_LATENCY - 1);
    end

    mcpu_mem_avl_rdq #(
        .CMDQ_LOG2 (CMDQ_LOG2)
    ) u_rdq (
        .clk        (clkrst_mem_clk),
        .rst_n      (clkrst_mem_rst_n),
        .push       (rd_acc),
        .push_cmd   (push_cmd),
        .pop        (pop),
        .head_cmd   (head_cmd),
        .head_ready (head_ready),
        .full       (cmdq_full),
        .empty      (cmdq_empty)
    );

    // Popping on the edge the last beat leaves lets bursts follow each other without a gap.
    assign pop     = head_ready && (rd_rem_q == '0);
    assign rd_en   = pop || (rd_rem_q != '0);
    assign rd_addr = pop ? head_cmd.base[MEM_LOG2-1:0] : rd_ptr_q;

    always_ff @(posedge clkrst_mem_clk or negedge clkrst_mem_rst_n) begin
        if (!clkrst_mem_rst_n) begin
            rd_ptr_q                 <= '0;
            rd_rem_q                 <= '0;
            ltc2mc_avl_rdata_0       <= '0;
            ltc2mc_avl_rdata_valid_0 <= 1'b0;
        end else begin
            ltc2mc_avl_rdata_valid_0 <= rd_en;
            if (rd_en) begin
                ltc2mc_avl_rdata_0 <= mem_q[rd_addr];
                rd_ptr_q           <= rd_addr + 1'b1;
            end
            if (pop) begin
                rd_rem_q <= head_cmd.size - 1'b1;
            end else if (rd_rem_q != '0) begin
                rd_rem_q <= rd_rem_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clkrst_mem_clk or negedge clkrst_mem_rst_n) begin
        if (!clkrst_mem_rst_n) begin
            avl_err <= 1'b0;
        end else if (err_set) begin
            avl_err <= 1'b1;
        end
    end

endmodule

// File: doc/mcpu_mem_avl_responder.md
Name: mcpu_mem_avl_responder

Overview:
- Avalon-MM burst responder that models the DDR memory controller on the ltc2mc_avl_*_0 port.
- It is the slave end of the interface driven by the last-level cache (MCPU_MEM_ltc).
- It accepts write and read bursts, holds data in an internal synchronous word array, and returns read beats after a fixed minimum latency.
- Used in arbiter/LTC benches, and in FPGA bring-up builds without the hard memory controller.

Parameters:
- MEM_LOG2, 10, log2 of backing-store depth in 128-bit words; address bits above this are ignored, giving modulo wrap.
- READ_LATENCY, 4, minimum number of cycles from read-command acceptance to its first rdata_valid beat; legal range 2..15.
- CMDQ_LOG2, 2, log2 of read-command queue depth.
- STALL_EN, 0, 1 enables pseudo-random ready deassertion.
- LFSR_SEED, 16'hACE1, reset value of the stall LFSR; must be nonzero.

Ports:
- clkrst_mem_clk  in  1  memory clock; all state is on the rising edge.
- clkrst_mem_rst_n  in  1  asynchronous active-low reset.
- ltc2mc_avl_addr_0  in  25  word address (16 B units), sampled on burst first beat.
- ltc2mc_avl_be_0  in  16  byte enables for the write beat.
- ltc2mc_avl_burstbegin_0  in  1  marks the first beat of a burst.
- ltc2mc_avl_read_req_0  in  1  read command.
- ltc2mc_avl_write_req_0  in  1  write beat.
- ltc2mc_avl_size_0  in  5  burst length in beats, sampled on first beat.
- ltc2mc_avl_wdata_0  in  128  write data.
- ltc2mc_avl_ready_0  out  1  request accepted on any edge where ready=1 and a request is asserted.
- ltc2mc_avl_rdata_0  out  128  read data.
- ltc2mc_avl_rdata_valid_0  out  1  read beat valid.
- avl_err  out  1  sticky protocol-error flag.

Behaviour:
- Reset (async assert): ready=0, rdata=0, rdata_valid=0, avl_err=0. Write FSM goes to IDLE, command queue empties, in-flight beats are dropped, LFSR is set to LFSR_SEED. Array contents are not reset.
- Reset is released synchronously internally. ready may rise on the first edge after deassertion.
- ready (combinational) = !stall && !cmdq_full && !(write_req && state==IDLE && rd_busy).
  - rd_busy means the queue is non-empty or the read engine is emitting.
  - Consequence: a new write burst is held off until every outstanding read has drained, so reads see all earlier writes and no later ones.
- stall: 0 when STALL_EN=0. Otherwise LFSR[1:0]==0, where the LFSR is a 16-bit Galois LFSR, taps 16,14,13,11, advancing every cycle.
- Write FSM: IDLE, WBURST.
  - IDLE, accepted write_req with burstbegin: latch base=addr[MEM_LOG2-1:0], write beat 0 with byte enables, set rem=size-1. Go to WBURST if rem>0.
  - WBURST, accepted write_req: write at base+k (k increments, wraps modulo 2^MEM_LOG2) and decrement rem. Return to IDLE when rem reaches 0.
  - Write beats land in the array at the acceptance edge.
- Read path:
  - An accepted read_req with burstbegin pushes {base, size, countdown=READ_LATENCY-1} into the queue.
  - The head entry's countdown decrements each cycle; every entry's countdown runs concurrently from its push.
  - When the head countdown is 0 and the engine is idle, the engine pops the entry and emits size beats on consecutive cycles, with addresses base, base+1, … wrapping.
  - Array read is synchronous. Beat n of a command accepted at edge T appears at T+READ_LATENCY+n when no earlier burst is occupying the output.
  - Back-to-back commands: the next burst's first beat is at max(previous last beat+1, T+READ_LATENCY).
- Errors: each sets avl_err, which stays set until reset.
  - size==0: the burst is treated as size 1.
  - read_req and write_req both high: the read is accepted and the write is ignored.
  - write_req without burstbegin in IDLE: the beat is dropped.
  - burstbegin or read_req during WBURST: burstbegin restarts a new write burst; read_req is dropped.
- rdata holds its last value when rdata_valid=0.

Decomposition:
- Package mcpu_mem_avl_pkg holds:
  - AVL_ADDR_W=25, AVL_DATA_W=128, AVL_BE_W=16, AVL_SIZE_W=5.
  - Write FSM state enum.
  - Read-command struct {base, size, countdown}.
- One sub-module, mcpu_mem_avl_rdq: a read-command FIFO with per-entry countdowns, full/empty flags and a head-ready output.
- The top level holds the write FSM, the array, the beat emitter and the LFSR.

Test Plan:
- Write size 2 at addr 0x10 (be all ones, data A, B); then read size 2 at 0x10 issued at edge T → rdata_valid at T+4 and T+5 with data A, B; avl_err=0.
- Write with be=16'h00FF, data 0xFF..FF, over a word holding 0 → read returns low 8 bytes 0xFF and high 8 bytes 0.
- Four read commands of size 1, back to back, with CMDQ_LOG2=2 → the fifth is held with ready=0 until the first pop; beats come out in command order with no gaps after the first.
- Read outstanding, then write_req with burstbegin → ready=0 until the last rdata_valid beat, ready=1 the cycle after; the read data excludes the new write.
- Write at addr 2^MEM_LOG2-1 with size 2 → the second beat lands at word 0; reading word 0 returns it.
- Reset asserted mid read burst → rdata_valid drops immediately, with no further beats after release; size=0 write → avl_err=1, one beat written.
